// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot combinational grant, searching upward from the port after the
// last granted one. The pointer moves only when the caller reports an actual grant.
module rr_arbiter #(
  parameter int unsigned PORT_NUM = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [PORT_NUM-1:0] req_i,
  input  logic                advance_i,
  output logic [PORT_NUM-1:0] gnt_o
);

  localparam int unsigned IDX_W = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;

  logic [IDX_W-1:0] last_q, last_d;
  logic [IDX_W-1:0] idx;
  logic             found;

  always_comb begin
    gnt_o  = '0;
    last_d = last_q;
    found  = 1'b0;
    idx    = '0;
    for (int k = 1; k <= int'(PORT_NUM); k++) begin
      idx = IDX_W'((int'(last_q) + k) % int'(PORT_NUM));
      if (!found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        last_d     = idx;
      end
    end
  end

  // Reset to the last port so that port 0 is searched first.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q <= IDX_W'(PORT_NUM - 1);
    end else if (advance_i) begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/arb_mux.sv
// Round-robin arbitrating multiplexer: merges PORT_NUM valid/ready sources onto one registered
// output, reporting the winning source as a one-hot grant for routing responses back.
module arb_mux #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PORT_NUM   = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [DATA_WIDTH*PORT_NUM-1:0] data_i,
  input  logic [PORT_NUM-1:0]            valid_i,
  output logic [PORT_NUM-1:0]            ready_o,
  output logic [DATA_WIDTH-1:0]          data_o,
  output logic                           valid_o,
  input  logic                           ready_i,
  output logic [PORT_NUM-1:0]            grant_o
);

  logic [PORT_NUM-1:0]   gnt;
  logic [DATA_WIDTH-1:0] mux_data;
  logic                  load;
  logic                  any_req;
  logic                  advance;

  logic [DATA_WIDTH-1:0] data_q;
  logic                  valid_q;
  logic [PORT_NUM-1:0]   grant_q;

  assign load    = !valid_q || ready_i;
  assign any_req = |valid_i;
  assign advance = load && any_req;
  assign ready_o = gnt & {PORT_NUM{load}};

  rr_arbiter #(
    .PORT_NUM (PORT_NUM)
  ) u_rr_arbiter (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .req_i     (valid_i),
    .advance_i (advance),
    .gnt_o     (gnt)
  );

  // AND-OR selection from the one-hot grant, mirroring the demux fan-out.
  always_comb begin
    mux_data = '0;
    for (int i = 0; i < int'(PORT_NUM); i++) begin
      mux_data = mux_data | (data_i[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{gnt[i]}});
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      grant_q <= '0;
    end else if (load) begin
      if (any_req) begin
        data_q  <= mux_data;
        valid_q <= 1'b1;
        grant_q <= gnt;
      end else begin
        valid_q <= 1'b0;
        grant_q <= '0;
      end
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign grant_o = grant_q;

endmodule
